// File: rtl/nn_dense_layer_pkg.sv
// nn_pkg: shared types and helpers for the neural-network datapath blocks.
//   nn_state_e - sequencing states of the time-multiplexed dense layer
//   acc_width  - accumulator width that cannot overflow for a NUM_IN-term dot product
//   sat_val    - clamp a signed value to a signed or unsigned OUT_W-bit range;
//                also used by the output-neuron and backprop blocks
package nn_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MAC  = 2'd1,
        ST_WB   = 2'd2,
        ST_DONE = 2'd3
    } nn_state_e;

    // Product of an unsigned IN_W value and a signed W_W value needs IN_W+W_W+1
    // bits; summing NUM_IN of them adds clog2(NUM_IN) bits of growth.
    function automatic int acc_width(input int in_w, input int w_w, input int num_in);
        return in_w + w_w + $clog2(num_in) + 1;
    endfunction

    // Unsigned mode clamps to [0, 2^out_w-1], which also implements ReLU.
    // Signed mode clamps to [-2^(out_w-1), 2^(out_w-1)-1].
    function automatic logic signed [63:0] sat_val(input logic signed [63:0] v,
                                                   input int                 out_w,
                                                   input logic               unsigned_out);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        if (unsigned_out) begin
            hi = (64'sd1 <<< out_w) - 64'sd1;
            lo = 64'sd0;
        end else begin
            hi = (64'sd1 <<< (out_w - 1)) - 64'sd1;
            lo = -(64'sd1 <<< (out_w - 1));
        end
        if (v > hi) return hi;
        if (v < lo) return lo;
        return v;
    endfunction

endpackage

// File: rtl/nn_dense_layer_mac_unit.sv
// nn_mac_unit: registered signed multiply-accumulate.
//   clk, rst - clock, asynchronous active-high reset
//   clr      - zero the accumulator (has priority over en)
//   en       - add x*w to the accumulator
//   x        - unsigned operand, zero-extended
//   w        - two's complement operand, sign-extended
//   acc      - accumulator value
module nn_mac_unit #(
    parameter int IN_W  = 4,
    parameter int W_W   = 8,
    parameter int ACC_W = 15
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clr,
    input  logic                    en,
    input  logic [IN_W-1:0]         x,
    input  logic signed [W_W-1:0]   w,
    output logic signed [ACC_W-1:0] acc
);

    logic signed [ACC_W-1:0] x_ext_p0;
    logic signed [ACC_W-1:0] w_ext_p0;
    logic signed [ACC_W-1:0] prod_p0;
    logic signed [ACC_W-1:0] acc_p1;

    assign x_ext_p0 = {{(ACC_W-IN_W){1'b0}}, x};
    assign w_ext_p0 = {{(ACC_W-W_W){w[W_W-1]}}, w};
    assign prod_p0  = x_ext_p0 * w_ext_p0;

    // ---- stage p0 -> p1: accumulate ----
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            acc_p1 <= '0;
        else if (clr)
            acc_p1 <= '0;
        else if (en)
            acc_p1 <= acc_p1 + prod_p0;
    end

    assign acc = acc_p1;

endmodule

// File: rtl/nn_dense_layer.sv
// nn_dense_layer: time-multiplexed fully-connected layer, NUM_OUT neurons over
// NUM_IN inputs, one shared MAC, internal weight register file.
//   clk_i, rst_i     - clock, asynchronous active-high reset
//   start_i          - request an evaluation (accepted in IDLE only)
//   x_i              - input vector, x[i] = x_i[i*IN_W +: IN_W], unsigned
//   w_we_i/addr/data - weight write port, addr = j*NUM_IN + i; dropped while busy
//   busy_o           - evaluation in progress
//   done_o           - one-cycle completion pulse
//   y_valid_o        - y_o holds the results of the last completed evaluation
//   y_o              - saturated results, y[j] = y_o[j*OUT_W +: OUT_W]
// Build option: define NN_DENSE_LAYER_RELU_EN for fused ReLU with unsigned
// clamped outputs; otherwise outputs are signed and saturated.
module nn_dense_layer
    import nn_pkg::*;
#(
    parameter int NUM_IN  = 4,
    parameter int NUM_OUT = 2,
    parameter int IN_W    = 4,
    parameter int W_W     = 8,
    parameter int OUT_W   = 10,
    localparam int ADDR_W = (NUM_IN*NUM_OUT > 1) ? $clog2(NUM_IN*NUM_OUT) : 1
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      start_i,
    input  logic [NUM_IN*IN_W-1:0]    x_i,
    input  logic                      w_we_i,
    input  logic [ADDR_W-1:0]         w_addr_i,
    input  logic signed [W_W-1:0]     w_data_i,
    output logic                      busy_o,
    output logic                      done_o,
    output logic                      y_valid_o,
    output logic [NUM_OUT*OUT_W-1:0]  y_o
);

`ifdef NN_DENSE_LAYER_RELU_EN
    localparam logic RELU_EN = 1'b1;
`else
    localparam logic RELU_EN = 1'b0;
`endif

    localparam int ACC_W = acc_width(IN_W, W_W, NUM_IN);
    localparam int N_W   = NUM_IN * NUM_OUT;
    localparam int I_W   = (NUM_IN  > 1) ? $clog2(NUM_IN)  : 1;
    localparam int J_W   = (NUM_OUT > 1) ? $clog2(NUM_OUT) : 1;
    localparam logic [I_W-1:0]  I_LAST = I_W'(NUM_IN - 1);
    localparam logic [J_W-1:0]  J_LAST = J_W'(NUM_OUT - 1);
    localparam logic [ADDR_W:0] N_W_L  = (ADDR_W+1)'(N_W);

    nn_state_e state, state_nxt;

    logic [I_W-1:0]          i_cnt;
    logic [J_W-1:0]          j_cnt;
    logic [IN_W-1:0]         x_q [NUM_IN];
    logic signed [W_W-1:0]   w_q [N_W];
    logic [OUT_W-1:0]        y_q [NUM_OUT];
    logic                    y_valid_q;
    logic signed [ACC_W-1:0] acc;
    logic                    start_ok;
    logic                    busy;
    logic                    done;
    logic                    mac_en;
    logic                    mac_clr;
    logic [ADDR_W-1:0]       rd_addr;
    logic signed [63:0]      sat_res;

    // State register
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)
            state <= ST_IDLE;
        else
            state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (start_i) state_nxt = ST_MAC;
            ST_MAC:  if (i_cnt == I_LAST) state_nxt = ST_WB;
            ST_WB:   state_nxt = (j_cnt == J_LAST) ? ST_DONE : ST_MAC;
            ST_DONE: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Output / control decode; everything here is driven from registered state
    // except start_ok, which stays internal.
    always_comb begin
        busy     = (state == ST_MAC) || (state == ST_WB);
        done     = (state == ST_DONE);
        start_ok = (state == ST_IDLE) && start_i;
        mac_en   = (state == ST_MAC);
        // Clearing on start as well guarantees a clean accumulator even if a
        // previous evaluation was cut short.
        mac_clr  = (state == ST_WB) || start_ok;
    end

    always_comb begin
        rd_addr = ADDR_W'(int'(j_cnt) * NUM_IN + int'(i_cnt));
        sat_res = sat_val(64'(acc), OUT_W, RELU_EN);
    end

    // ---- stage p0: operand fetch from snapshot and weight file ----
    nn_mac_unit #(
        .IN_W  (IN_W),
        .W_W   (W_W),
        .ACC_W (ACC_W)
    ) u_mac (
        .clk (clk_i),
        .rst (rst_i),
        .clr (mac_clr),
        .en  (mac_en),
        .x   (x_q[i_cnt]),
        .w   (w_q[rd_addr]),
        .acc (acc)
    );

    // ---- stage p1: counters, input snapshot, write-back ----
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            i_cnt     <= '0;
            j_cnt     <= '0;
            y_valid_q <= 1'b0;
            for (int k = 0; k < NUM_IN; k++)  x_q[k] <= '0;
            for (int k = 0; k < NUM_OUT; k++) y_q[k] <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start_i) begin
                        i_cnt     <= '0;
                        j_cnt     <= '0;
                        y_valid_q <= 1'b0;
                        for (int k = 0; k < NUM_IN; k++)
                            x_q[k] <= x_i[k*IN_W +: IN_W];
                    end
                end
                ST_MAC: begin
                    if (i_cnt != I_LAST)
                        i_cnt <= i_cnt + 1'b1;
                end
                ST_WB: begin
                    y_q[j_cnt] <= sat_res[OUT_W-1:0];
                    i_cnt      <= '0;
                    // Raising valid here makes it high in the DONE cycle.
                    if (j_cnt != J_LAST)
                        j_cnt <= j_cnt + 1'b1;
                    else
                        y_valid_q <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Weight file: writes only while not busy (IDLE or DONE).
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int k = 0; k < N_W; k++) w_q[k] <= '0;
        end else if (w_we_i && !busy && ({1'b0, w_addr_i} < N_W_L)) begin
            w_q[w_addr_i] <= w_data_i;
        end
    end

    assign busy_o    = busy;
    assign done_o    = done;
    assign y_valid_o = y_valid_q;

    for (genvar g = 0; g < NUM_OUT; g++) begin : g_y
        assign y_o[g*OUT_W +: OUT_W] = y_q[g];
    end

endmodule
